// File: rtl/bolme_birimi_pkg.sv
// Shared definitions for the RV32M divider: operation select codes and FSM states.
package bolme_birimi_pkg;

  // islem_i encodings
  localparam logic [1:0] BOLME_DIV  = 2'b00;
  localparam logic [1:0] BOLME_DIVU = 2'b01;
  localparam logic [1:0] BOLME_REM  = 2'b10;
  localparam logic [1:0] BOLME_REMU = 2'b11;

  typedef enum logic [1:0] {
    StBosta   = 2'b00,
    StHesapla = 2'b01,
    StBitti   = 2'b10
  } durum_e;

endpackage

// File: rtl/bolme_birimi.sv
// bolme_birimi: multi-cycle RV32M divider (DIV/DIVU/REM/REMU) for the yurut stage.
// Radix-2 restoring division on operand magnitudes, one quotient bit per cycle, with the
// sign fix-up applied as the result is registered. Division by zero and signed overflow
// are answered directly without iterating.
// Ports:
//   clk_i      clock
//   rst_i      asynchronous, active-high reset
//   istek_i    division op present in yurut; held high while stalled
//   islem_i    op select (BOLME_DIV/DIVU/REM/REMU)
//   bolunen_i  dividend (rs1), sampled only on acceptance
//   bolen_i    divisor (rs2), sampled only on acceptance
//   sonuc_o    quotient or remainder, registered
//   bitti_o    1 = idle or result ready; 0 = stall the pipeline
module bolme_birimi
  import bolme_birimi_pkg::*;
#(
  parameter int unsigned VERI_BIT = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                istek_i,
  input  logic [1:0]          islem_i,
  input  logic [VERI_BIT-1:0] bolunen_i,
  input  logic [VERI_BIT-1:0] bolen_i,
  output logic [VERI_BIT-1:0] sonuc_o,
  output logic                bitti_o
);

  localparam int unsigned SayacW = $clog2(VERI_BIT + 1);
  localparam logic [VERI_BIT-1:0] Sifir   = '0;
  localparam logic [VERI_BIT-1:0] Birler  = '1;
  localparam logic [VERI_BIT-1:0] EnKucuk = {1'b1, {(VERI_BIT-1){1'b0}}};

  durum_e              r_durum, w_durum_d;
  logic [SayacW-1:0]   r_sayac, w_sayac_d;
  logic [VERI_BIT-1:0] r_kalan, w_kalan_d;   // partial remainder
  logic [VERI_BIT-1:0] r_bolum, w_bolum_d;   // dividend shifting out / quotient shifting in
  logic [VERI_BIT-1:0] r_bolen, w_bolen_d;   // divisor magnitude
  logic                r_bolum_neg, w_bolum_neg_d;
  logic                r_kalan_neg, w_kalan_neg_d;
  logic                r_kalan_mi, w_kalan_mi_d;
  logic [VERI_BIT-1:0] r_sonuc, w_sonuc_d;

  // Operand decode at acceptance
  logic                w_isaretli, w_kalan_mi, w_a_neg, w_b_neg, w_sifir, w_tasma;
  logic [VERI_BIT-1:0] w_a_mut, w_b_mut;

  assign w_isaretli = (islem_i == BOLME_DIV) || (islem_i == BOLME_REM);
  assign w_kalan_mi = (islem_i == BOLME_REM) || (islem_i == BOLME_REMU);
  assign w_a_neg    = w_isaretli & bolunen_i[VERI_BIT-1];
  assign w_b_neg    = w_isaretli & bolen_i[VERI_BIT-1];
  // |-2^(N-1)| wraps to 2^(N-1), which is exactly right when read as unsigned.
  assign w_a_mut    = w_a_neg ? (Sifir - bolunen_i) : bolunen_i;
  assign w_b_mut    = w_b_neg ? (Sifir - bolen_i) : bolen_i;
  assign w_sifir    = (bolen_i == Sifir);
  assign w_tasma    = w_isaretli && (bolunen_i == EnKucuk) && (bolen_i == Birler);

  // One restoring step
  logic [VERI_BIT:0]   w_kaydir;
  logic                w_ge;
  logic [VERI_BIT-1:0] w_fark, w_kalan_yeni, w_bolum_yeni, w_q_son, w_r_son;

  assign w_kaydir     = {r_kalan, r_bolum[VERI_BIT-1]};
  assign w_ge         = (w_kaydir >= {1'b0, r_bolen});
  // When w_ge holds the true difference is below the divisor, so the low bits suffice.
  assign w_fark       = w_kaydir[VERI_BIT-1:0] - r_bolen;
  assign w_kalan_yeni = w_ge ? w_fark : w_kaydir[VERI_BIT-1:0];
  assign w_bolum_yeni = {r_bolum[VERI_BIT-2:0], w_ge};
  assign w_q_son      = r_bolum_neg ? (Sifir - w_bolum_yeni) : w_bolum_yeni;
  assign w_r_son      = r_kalan_neg ? (Sifir - w_kalan_yeni) : w_kalan_yeni;

  always_comb begin
    w_durum_d     = r_durum;
    w_sayac_d     = r_sayac;
    w_kalan_d     = r_kalan;
    w_bolum_d     = r_bolum;
    w_bolen_d     = r_bolen;
    w_bolum_neg_d = r_bolum_neg;
    w_kalan_neg_d = r_kalan_neg;
    w_kalan_mi_d  = r_kalan_mi;
    w_sonuc_d     = r_sonuc;
    unique case (r_durum)
      StBosta: begin
        if (istek_i) begin
          if (w_sifir) begin
            w_sonuc_d = w_kalan_mi ? bolunen_i : Birler;
            w_durum_d = StBitti;
          end else if (w_tasma) begin
            w_sonuc_d = w_kalan_mi ? Sifir : EnKucuk;
            w_durum_d = StBitti;
          end else begin
            w_kalan_d     = Sifir;
            w_bolum_d     = w_a_mut;
            w_bolen_d     = w_b_mut;
            w_bolum_neg_d = w_a_neg ^ w_b_neg;
            w_kalan_neg_d = w_a_neg;
            w_kalan_mi_d  = w_kalan_mi;
            w_sayac_d     = SayacW'(VERI_BIT);
            w_durum_d     = StHesapla;
          end
        end
      end
      StHesapla: begin
        w_kalan_d = w_kalan_yeni;
        w_bolum_d = w_bolum_yeni;
        w_sayac_d = r_sayac - SayacW'(1);
        if (r_sayac == SayacW'(1)) begin
          w_sonuc_d = r_kalan_mi ? w_r_son : w_q_son;
          w_durum_d = StBitti;
        end
      end
      StBitti: w_durum_d = StBosta;
      default: w_durum_d = StBosta;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_durum     <= StBosta;
      r_sayac     <= '0;
      r_kalan     <= '0;
      r_bolum     <= '0;
      r_bolen     <= '0;
      r_bolum_neg <= 1'b0;
      r_kalan_neg <= 1'b0;
      r_kalan_mi  <= 1'b0;
      r_sonuc     <= '0;
    end else begin
      r_durum     <= w_durum_d;
      r_sayac     <= w_sayac_d;
      r_kalan     <= w_kalan_d;
      r_bolum     <= w_bolum_d;
      r_bolen     <= w_bolen_d;
      r_bolum_neg <= w_bolum_neg_d;
      r_kalan_neg <= w_kalan_neg_d;
      r_kalan_mi  <= w_kalan_mi_d;
      r_sonuc     <= w_sonuc_d;
    end
  end

  assign sonuc_o = r_sonuc;
  // Reset overrides a pending request so the pipeline is never stalled during reset.
  assign bitti_o = rst_i | ~((r_durum == StHesapla) | ((r_durum == StBosta) & istek_i));

endmodule

// File: tb/tb_bolme_birimi.sv
// Directed self-checking bench for bolme_birimi.
module tb_bolme_birimi;
  import bolme_birimi_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        istek = 1'b0;
  logic [1:0]  islem = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] sonuc;
  logic        bitti;

  int n_test = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bolme_birimi #(
    .VERI_BIT(32)
  ) u_dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .istek_i  (istek),
    .islem_i  (islem),
    .bolunen_i(a),
    .bolen_i  (b),
    .sonuc_o  (sonuc),
    .bitti_o  (bitti)
  );

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                         input logic [31:0] beklenen);
    n_test++;
    if (gozlenen !== beklenen) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", etiket, gozlenen, beklenen);
    end
  endtask

  // Issue one op, count cycles with bitti low, then check latency and result in BITTI.
  // Operands are scrambled after acceptance to show they are not re-sampled.
  task automatic islem_yap(input string etiket, input logic [1:0] op, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] beklenen,
                           input int gecikme, input bit tut);
    int n;
    n = 0;
    @(negedge clk);
    islem = op;
    a     = x;
    b     = y;
    istek = 1'b1;
    #1;
    while (!bitti && n < 100) begin
      n++;
      @(negedge clk);
      if (n == 1) begin
        a = $urandom;
        b = $urandom;
      end
      #1;
    end
    kontrol({etiket, "_lat"}, 32'(n), 32'(gecikme));
    kontrol(etiket, sonuc, beklenen);
    if (!tut) istek = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with a request pending to show reset forces bitti high
    istek = 1'b1;
    #1;
    kontrol("rst_bitti", {31'd0, bitti}, 32'd1);
    kontrol("rst_sonuc", sonuc, 32'd0);
    @(negedge clk);
    istek = 1'b0;
    rst   = 1'b0;
    #1;
    kontrol("idle_bitti", {31'd0, bitti}, 32'd1);

    // 1: unsigned
    islem_yap("divu_100_7", BOLME_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    @(negedge clk);
    #1;
    kontrol("idle_hold_bitti", {31'd0, bitti}, 32'd1);
    kontrol("idle_hold_sonuc", sonuc, 32'd14);
    islem_yap("remu_100_7", BOLME_REMU, 32'd100, 32'd7, 32'd2, 33, 1'b0);

    // 2: signed
    islem_yap("div_m20_3", BOLME_DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33, 1'b0);
    islem_yap("rem_m20_3", BOLME_REM, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33, 1'b0);
    islem_yap("div_20_m3", BOLME_DIV, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 33, 1'b0);
    islem_yap("rem_20_m3", BOLME_REM, 32'd20, 32'hFFFF_FFFD, 32'd2, 33, 1'b0);

    // 3: divide by zero
    islem_yap("divu_5_0", BOLME_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
    islem_yap("rem_5_0", BOLME_REM, 32'd5, 32'd0, 32'd5, 1, 1'b0);
    islem_yap("div_m5_0", BOLME_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);

    // 4: signed overflow
    islem_yap("div_ovf", BOLME_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
    islem_yap("rem_ovf", BOLME_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);

    // Magnitude boundaries
    islem_yap("div_min_2", BOLME_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 33, 1'b0);
    islem_yap("divu_min_1", BOLME_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 1'b0);
    islem_yap("remu_big", BOLME_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33, 1'b0);

    // 5: back-to-back with istek held
    islem_yap("b2b_divu", BOLME_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 1'b1);
    islem_yap("b2b_remu", BOLME_REMU, 32'd9, 32'd4, 32'd1, 33, 1'b0);

    // 6: reset mid-operation
    @(negedge clk);
    islem = BOLME_DIV;
    a     = 32'h7FFF_FFFF;
    b     = 32'd3;
    istek = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    kontrol("midrst_bitti", {31'd0, bitti}, 32'd1);
    kontrol("midrst_sonuc", sonuc, 32'd0);
    @(negedge clk);
    #1;
    kontrol("midrst_sonuc2", sonuc, 32'd0);
    rst   = 1'b0;
    istek = 1'b0;
    islem_yap("post_rst_div", BOLME_DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end

endmodule
